// File: rtl/reg_file_2r1w_pkg.sv
// regfile_pkg: register file geometry and operand types shared with decode and writeback
package regfile_pkg;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int ADDR_W = 3;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [WIDTH-1:0] reg_data_t;
  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/reg_file_2r1w_if.sv
// reg_file_2r1w_if: write port, two read ports and the register-0 write error flag
interface reg_file_2r1w_if;
  import regfile_pkg::*;
  logic WE;
  reg_addr_t WA;
  reg_data_t WD;
  reg_addr_t RA1;
  reg_addr_t RA2;
  reg_data_t RD1;
  reg_data_t RD2;
  logic RV1;
  logic RV2;
  logic WERR;
  modport master (output WE, WA, WD, RA1, RA2, input RD1, RD2, RV1, RV2, WERR);
  modport slave (input WE, WA, WD, RA1, RA2, output RD1, RD2, RV1, RV2, WERR);
endinterface

// File: rtl/reg_file_2r1w_reg_cell.sv
// reg_cell: one falling-edge register with its written-since-reset bit
module reg_cell
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      we,
  input  reg_data_t d,
  output reg_data_t q,
  output logic      v
);
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) begin
      q <= '0;
      v <= 1'b0;
    end else if (we) begin
      q <= d;
      v <= 1'b1;
    end
endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 2-read 1-write register file, r0 hardwired zero; REGFILE_BYPASS_EN adds write-to-read forwarding
module reg_file_2r1w
  import regfile_pkg::*;
(
  input logic             CLK,
  input logic             R_,
  reg_file_2r1w_if.slave  bus
);
  reg_data_t regs [DEPTH];
  logic [DEPTH-1:0] vld;
  logic werr;
  assign regs[0] = '0;
  assign vld[0] = R_;
  for (genvar i = 1; i < DEPTH; i++) begin : g_cell
    reg_cell u_cell (
      .clk   (CLK),
      .rst_n (R_),
      .we    (bus.WE && bus.WA == reg_addr_t'(i)),
      .d     (bus.WD),
      .q     (regs[i]),
      .v     (vld[i])
    );
  end
  always_ff @(negedge CLK or negedge R_)
    if (!R_) werr <= 1'b0;
    else if (bus.WE && bus.WA == REG_ZERO) werr <= 1'b1;
  assign bus.WERR = werr;
`ifdef REGFILE_BYPASS_EN
  logic byp1, byp2;
  // gated by R_ so reset still forces zero reads
  assign byp1 = R_ && bus.WE && bus.WA != REG_ZERO && bus.RA1 == bus.WA;
  assign byp2 = R_ && bus.WE && bus.WA != REG_ZERO && bus.RA2 == bus.WA;
  assign bus.RD1 = byp1 ? bus.WD : regs[bus.RA1];
  assign bus.RD2 = byp2 ? bus.WD : regs[bus.RA2];
  assign bus.RV1 = byp1 | vld[bus.RA1];
  assign bus.RV2 = byp2 | vld[bus.RA2];
`else
  assign bus.RD1 = regs[bus.RA1];
  assign bus.RD2 = regs[bus.RA2];
  assign bus.RV1 = vld[bus.RA1];
  assign bus.RV2 = vld[bus.RA2];
`endif
endmodule
